uart_rx: RTL and testbench

- Serial receiver that sits directly downstream of the team's 8N1 transmitter.
- It consumes the idle-high serial line: start bit (0), 8 data bits LSB-first, stop bit (1).
- It oversamples the line at 16x the bit rate, assembles each byte, and presents it in parallel with a one-cycle completion strobe.
- It flags framing errors (bad stop bit) and overrun (new byte completed before the previous one was acknowledged).

---
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 16x oversampling, parallel byte out with completion strobe,
// sticky framing-error and overrun flags cleared by ReadAck.
//
// state   | meaning
// IDLE    | line idle, waiting for a low sample on a tick
// START   | counting to mid start bit to reject glitches
// DATA    | sampling 8 data bits LSB-first at bit centre
// STOP    | sampling stop bit, then delivering the byte
module uart_rx #(
  parameter int TICK_DIV = 326
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       SerialIn,
  output logic [7:0] DataOut,
  output logic       charReceived,
  output logic       FramingError,
  output logic       Overrun,
  output logic       DataValid,
  input  logic       ReadAck
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [11:0] TICK_MAX = 12'(TICK_DIV - 1);

  logic [11:0] tick_cnt_q, tick_cnt_d;
  logic        tick;
  logic        rx_meta_q, rx_s_q;
  logic [1:0]  state_q, state_d;
  logic [3:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        char_rx_q, char_rx_d;
  logic        fe_q, fe_d;
  logic        ovr_q, ovr_d;
  logic        dv_q, dv_d;
  logic        complete;

  always_comb begin
    tick       = (tick_cnt_q == TICK_MAX);
    tick_cnt_d = tick ? 12'd0 : tick_cnt_q + 12'd1;
  end

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    complete   = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d    = S_START;
            samp_cnt_d = 4'd0;
          end
        end
        S_START: begin
          if (samp_cnt_q == 4'd7) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_DATA;
              samp_cnt_d = 4'd0;
              bit_idx_d  = 3'd0;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (samp_cnt_q == 4'd15) begin
            shreg_d    = {rx_s_q, shreg_q[7:1]};
            bit_idx_d  = bit_idx_q + 3'd1;
            samp_cnt_d = 4'd0;
            if (bit_idx_q == 3'd7) state_d = S_STOP;
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (samp_cnt_q == 4'd15) begin
            complete   = 1'b1;
            state_d    = S_IDLE;
            samp_cnt_d = 4'd0;
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A completion in the same cycle as ReadAck wins; flags then describe only the new frame.
  always_comb begin
    data_out_d = data_out_q;
    char_rx_d  = complete;
    fe_d       = fe_q;
    ovr_d      = ovr_q;
    dv_d       = dv_q;
    if (complete) begin
      data_out_d = shreg_q;
      dv_d       = 1'b1;
      if (ReadAck) begin
        ovr_d = 1'b0;
        fe_d  = !rx_s_q;
      end else begin
        ovr_d = ovr_q | dv_q;
        fe_d  = fe_q | !rx_s_q;
      end
    end else if (ReadAck) begin
      dv_d  = 1'b0;
      fe_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      tick_cnt_q <= 12'd0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      samp_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= 8'h00;
      data_out_q <= 8'h00;
      char_rx_q  <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rx_meta_q  <= SerialIn;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      char_rx_q  <= char_rx_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
      dv_q       <= dv_d;
    end
  end

  assign DataOut      = data_out_q;
  assign charReceived = char_rx_q;
  assign FramingError = fe_q;
  assign Overrun      = ovr_q;
  assign DataValid    = dv_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with TICK_DIV=4 (64 clocks per bit); drives 8N1 frames
// on SerialIn and checks outputs at negedges after each scenario.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       SerialIn = 1'b1;
  logic       ReadAck = 1'b0;
  logic [7:0] DataOut;
  logic       charReceived;
  logic       FramingError;
  logic       Overrun;
  logic       DataValid;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int base;

  always #5 clk = ~clk;

  uart_rx #(.TICK_DIV(4)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .SerialIn    (SerialIn),
    .DataOut     (DataOut),
    .charReceived(charReceived),
    .FramingError(FramingError),
    .Overrun     (Overrun),
    .DataValid   (DataValid),
    .ReadAck     (ReadAck)
  );

  // Counts strobe cycles, so a pulse longer than one cycle shows up as an extra strobe.
  always @(negedge clk) if (charReceived === 1'b1) strobe_cnt++;

  task automatic drive_bit(input logic b);
    SerialIn = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic ack_at_start);
    SerialIn = 1'b0;
    if (ack_at_start) ReadAck = 1'b1;
    @(negedge clk);
    ReadAck = 1'b0;
    repeat (BIT_CLKS - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
    SerialIn = 1'b1;
  endtask

  task automatic pulse_ack();
    ReadAck = 1'b1;
    @(negedge clk);
    ReadAck = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (DataOut !== 8'h00) begin failures++; $display("FAIL reset_dataout got %h want 00", DataOut); end
    checks++; if (charReceived !== 1'b0) begin failures++; $display("FAIL reset_strobe got %b want 0", charReceived); end
    checks++; if (FramingError !== 1'b0) begin failures++; $display("FAIL reset_fe got %b want 0", FramingError); end
    checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got %b want 0", Overrun); end
    checks++; if (DataValid !== 1'b0) begin failures++; $display("FAIL reset_dv got %b want 0", DataValid); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame();
    base = strobe_cnt;
    send_byte(8'hA5, 1'b1, 1'b0);
    checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL single_strobes got %0d want 1", strobe_cnt - base); end
    checks++; if (DataOut !== 8'hA5) begin failures++; $display("FAIL single_dataout got %h want a5", DataOut); end
    checks++; if (DataValid !== 1'b1) begin failures++; $display("FAIL single_dv got %b want 1", DataValid); end
    checks++; if (FramingError !== 1'b0) begin failures++; $display("FAIL single_fe got %b want 0", FramingError); end
    checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL single_ovr got %b want 0", Overrun); end
  endtask

  task automatic test_back_to_back();
    base = strobe_cnt;
    send_byte(8'h3C, 1'b1, 1'b1);
    checks++; if (DataOut !== 8'h3C) begin failures++; $display("FAIL b2b_first_data got %h want 3c", DataOut); end
    checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL b2b_first_strobes got %0d want 1", strobe_cnt - base); end
    send_byte(8'hC3, 1'b1, 1'b1);
    checks++; if (DataOut !== 8'hC3) begin failures++; $display("FAIL b2b_second_data got %h want c3", DataOut); end
    checks++; if (strobe_cnt - base !== 2) begin failures++; $display("FAIL b2b_strobes got %0d want 2", strobe_cnt - base); end
    checks++; if ({FramingError, Overrun, DataValid} !== 3'b001) begin failures++; $display("FAIL b2b_flags got fe/ovr/dv=%b want 001", {FramingError, Overrun, DataValid}); end
  endtask

  task automatic test_false_start();
    base = strobe_cnt;
    SerialIn = 1'b0;
    repeat (20) @(negedge clk);
    SerialIn = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (strobe_cnt - base !== 0) begin failures++; $display("FAIL glitch_strobes got %0d want 0", strobe_cnt - base); end
    checks++; if (DataOut !== 8'hC3) begin failures++; $display("FAIL glitch_dataout got %h want c3", DataOut); end
  endtask

  task automatic test_framing_error();
    pulse_ack();
    repeat (4) @(negedge clk);
    base = strobe_cnt;
    send_byte(8'h55, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL fe_strobes got %0d want 1", strobe_cnt - base); end
    checks++; if (DataOut !== 8'h55) begin failures++; $display("FAIL fe_dataout got %h want 55", DataOut); end
    checks++; if (FramingError !== 1'b1) begin failures++; $display("FAIL fe_flag got %b want 1", FramingError); end
    checks++; if (DataValid !== 1'b1) begin failures++; $display("FAIL fe_dv got %b want 1", DataValid); end
    pulse_ack();
    checks++; if (FramingError !== 1'b0) begin failures++; $display("FAIL fe_ack_clear got %b want 0", FramingError); end
    checks++; if (DataValid !== 1'b0) begin failures++; $display("FAIL fe_ack_dv got %b want 0", DataValid); end
  endtask

  task automatic test_overrun();
    base = strobe_cnt;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    checks++; if (strobe_cnt - base !== 2) begin failures++; $display("FAIL ovr_strobes got %0d want 2", strobe_cnt - base); end
    checks++; if (DataOut !== 8'h22) begin failures++; $display("FAIL ovr_dataout got %h want 22", DataOut); end
    checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got %b want 1", Overrun); end
    checks++; if (DataValid !== 1'b1) begin failures++; $display("FAIL ovr_dv got %b want 1", DataValid); end
    checks++; if (FramingError !== 1'b0) begin failures++; $display("FAIL ovr_fe got %b want 0", FramingError); end
  endtask

  task automatic test_reset_midframe();
    base = strobe_cnt;
    fork
      send_byte(8'hFF, 1'b1, 1'b0);
      begin
        repeat (BIT_CLKS * 5 + 32) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if ({DataOut, FramingError, Overrun, DataValid, charReceived} !== 12'h000) begin
          failures++; $display("FAIL midreset_outputs got data=%h fe=%b ovr=%b dv=%b str=%b want all 0", DataOut, FramingError, Overrun, DataValid, charReceived);
        end
      end
    join
    repeat (20) @(negedge clk);
    checks++; if (strobe_cnt - base !== 0) begin failures++; $display("FAIL midreset_strobes got %0d want 0", strobe_cnt - base); end
    checks++; if (DataOut !== 8'h00) begin failures++; $display("FAIL midreset_dataout got %h want 00", DataOut); end
    send_byte(8'h81, 1'b1, 1'b0);
    checks++; if (DataOut !== 8'h81) begin failures++; $display("FAIL after_reset_data got %h want 81", DataOut); end
    checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL after_reset_strobes got %0d want 1", strobe_cnt - base); end
    checks++; if ({FramingError, Overrun, DataValid} !== 3'b001) begin failures++; $display("FAIL after_reset_flags got fe/ovr/dv=%b want 001", {FramingError, Overrun, DataValid}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_false_start();
    test_framing_error();
    test_overrun();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
